// File: rtl/slot_io_pkg.sv
// Shared sizing constants for the slot push-button / DIP-switch input conditioner.
package slot_io_pkg;

  localparam int unsigned NUM_BTN                 = 2;
  localparam int unsigned NUM_SW                  = 4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_HOLD_CYCLES     = 50000000;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer, stability counter and a one-cycle toggle pulse
// that coincides with the first cycle the debounced level shows its new value.
module debounce_bit #(
  parameter int unsigned DebounceCycles = 1000000,
  parameter logic        ResetVal       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic toggle_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            toggle_q, toggle_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    level_d  = level_q;
    toggle_d = 1'b0;
    // Any cycle where the synchronized input agrees with the level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d  = ~level_q;
        toggle_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= ResetVal;
      sync2_q  <= ResetVal;
      level_q  <= ResetVal;
      toggle_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      toggle_q <= toggle_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o  = level_q;
  assign toggle_o = toggle_q;

endmodule

// File: rtl/slot_input_conditioner.sv
// Debounces the slot's push-buttons and DIP switches, producing press/change pulses
// and a per-button long-hold flag.
module slot_input_conditioner
  import slot_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [NUM_BTN-1:0] btn_n_in,
  input  logic [NUM_SW-1:0]  sw_in,
  output logic [NUM_BTN-1:0] btn_n_db,
  output logic [NUM_SW-1:0]  sw_db,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_hold,
  output logic [NUM_SW-1:0]  sw_change
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);

  logic [NUM_BTN-1:0]            btn_toggle;
  logic [NUM_BTN-1:0][HoldW-1:0] hold_cnt_q, hold_cnt_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .ResetVal      (1'b1)
    ) u_debounce (
      .clk_i   (clk_clk),
      .rst_i   (reset_reset),
      .raw_i   (btn_n_in[i]),
      .level_o (btn_n_db[i]),
      .toggle_o(btn_toggle[i])
    );
  end

  for (genvar j = 0; j < NUM_SW; j++) begin : g_sw
    debounce_bit #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .ResetVal      (1'b0)
    ) u_debounce (
      .clk_i   (clk_clk),
      .rst_i   (reset_reset),
      .raw_i   (sw_in[j]),
      .level_o (sw_db[j]),
      .toggle_o(sw_change[j])
    );
  end

  // Buttons are active-low, so only a toggle landing on 0 is a press.
  assign btn_press = btn_toggle & ~btn_n_db;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    btn_hold   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_n_db[i]) begin
        hold_cnt_d[i] = '0;
      end else if (hold_cnt_q[i] != HoldMax) begin
        hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
      end
      // Masked by the level so a release drops the flag before the counter clears.
      btn_hold[i] = ~btn_n_db[i] & (hold_cnt_q[i] == HoldMax);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_slot_input_conditioner.sv
// Scoreboard bench for slot_input_conditioner with DEBOUNCE_CYCLES = 8, HOLD_CYCLES = 20.
module tb_slot_input_conditioner;

  typedef struct packed {
    logic [1:0] btn_n_db;
    logic [3:0] sw_db;
    logic [1:0] press;
    logic [1:0] hold;
    logic [3:0] change;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic [1:0] btn_n_in = 2'b11;
  logic [3:0] sw_in = 4'b0000;
  logic [1:0] btn_n_db, btn_press, btn_hold;
  logic [3:0] sw_db, sw_change;

  obs_t sb[$];
  obs_t exp_v;
  int   checks = 0;
  int   failures = 0;

  slot_input_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (20)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(reset_reset),
    .btn_n_in   (btn_n_in),
    .sw_in      (sw_in),
    .btn_n_db   (btn_n_db),
    .sw_db      (sw_db),
    .btn_press  (btn_press),
    .btn_hold   (btn_hold),
    .sw_change  (sw_change)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {btn_n_db, sw_db, btn_press, btn_hold, sw_change};
  endfunction

  function automatic obs_t mk(logic [1:0] b, logic [3:0] s, logic [1:0] p, logic [1:0] h,
                              logic [3:0] ch);
    return {b, s, p, h, ch};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    btn_n_in    = 2'b11;
    sw_in       = 4'b0000;
    repeat (3) next_cycle();
    checks++;
    if (observe() !== mk(2'b11, 4'b0000, 2'b00, 2'b00, 4'b0000)) begin
      failures++;
      $display("FAIL reset_in_reset got=%b want=%b", observe(),
               mk(2'b11, 4'b0000, 2'b00, 2'b00, 4'b0000));
    end
    reset_reset = 1'b0;
    for (int c = 0; c < 50; c++) sb.push_back(mk(2'b11, 4'b0000, 2'b00, 2'b00, 4'b0000));
    for (int c = 0; c < 50; c++) begin
      exp_v = sb.pop_front();
      checks++;
      if (observe() !== exp_v) begin
        failures++;
        $display("FAIL reset_idle c=%0d got=%b want=%b", c, observe(), exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_press_hold();
    for (int c = 0; c < 40; c++)
      sb.push_back(mk((c >= 10) ? 2'b10 : 2'b11, 4'b0000, (c == 10) ? 2'b01 : 2'b00,
                      (c >= 30) ? 2'b01 : 2'b00, 4'b0000));
    // Release: level returns after 10 cycles, hold drops that same cycle, no pulse.
    for (int c = 0; c < 15; c++)
      sb.push_back(mk((c >= 10) ? 2'b11 : 2'b10, 4'b0000, 2'b00,
                      (c < 10) ? 2'b01 : 2'b00, 4'b0000));
    for (int c = 0; c < 55; c++) begin
      if (c == 0) btn_n_in = 2'b10;
      if (c == 40) btn_n_in = 2'b11;
      exp_v = sb.pop_front();
      checks++;
      if (observe() !== exp_v) begin
        failures++;
        $display("FAIL press_hold c=%0d got=%b want=%b", c, observe(), exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_bounce();
    logic pat[$];
    for (int r = 0; r < 3; r++) begin
      repeat (5) pat.push_back(1'b0);
      repeat (5) pat.push_back(1'b1);
    end
    // Two near-threshold lows split by a single high cycle must not accumulate.
    repeat (7) pat.push_back(1'b0);
    pat.push_back(1'b1);
    repeat (7) pat.push_back(1'b0);
    repeat (12) pat.push_back(1'b1);
    for (int c = 0; c < pat.size(); c++)
      sb.push_back(mk(2'b11, 4'b0000, 2'b00, 2'b00, 4'b0000));
    for (int c = 0; c < pat.size(); c++) begin
      btn_n_in = {pat[c], 1'b1};
      exp_v = sb.pop_front();
      checks++;
      if (observe() !== exp_v) begin
        failures++;
        $display("FAIL bounce c=%0d got=%b want=%b", c, observe(), exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_switch();
    for (int c = 0; c < 45; c++)
      sb.push_back(mk(2'b11, (c >= 10 && c < 30) ? 4'b1010 : 4'b0000, 2'b00, 2'b00,
                      (c == 10 || c == 30) ? 4'b1010 : 4'b0000));
    for (int c = 0; c < 45; c++) begin
      if (c == 0) sw_in = 4'b1010;
      if (c == 20) sw_in = 4'b0000;
      exp_v = sb.pop_front();
      checks++;
      if (observe() !== exp_v) begin
        failures++;
        $display("FAIL switch c=%0d got=%b want=%b", c, observe(), exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 35; c++)
      sb.push_back(mk((c >= 10 && c < 25) ? 2'b00 : 2'b11,
                      (c >= 10 && c < 25) ? 4'b0101 : 4'b0000,
                      (c == 10) ? 2'b11 : 2'b00, 2'b00,
                      (c == 10 || c == 25) ? 4'b0101 : 4'b0000));
    for (int c = 0; c < 35; c++) begin
      btn_n_in = (c < 15) ? 2'b00 : 2'b11;
      sw_in    = (c < 15) ? 4'b0101 : 4'b0000;
      exp_v = sb.pop_front();
      checks++;
      if (observe() !== exp_v) begin
        failures++;
        $display("FAIL simultaneous c=%0d got=%b want=%b", c, observe(), exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_hold();
    // Reset taken at edge 15; press re-fires 10 cycles later. The release lands exactly
    // when the hold counter saturates, so hold must never show.
    for (int c = 0; c < 50; c++)
      sb.push_back(mk(((c >= 10 && c <= 14) || (c >= 25 && c <= 44)) ? 2'b10 : 2'b11,
                      4'b0000, (c == 10 || c == 25) ? 2'b01 : 2'b00, 2'b00, 4'b0000));
    for (int c = 0; c < 50; c++) begin
      btn_n_in    = (c < 35) ? 2'b10 : 2'b11;
      reset_reset = (c == 14);
      exp_v = sb.pop_front();
      checks++;
      if (observe() !== exp_v) begin
        failures++;
        $display("FAIL reset_mid_hold c=%0d got=%b want=%b", c, observe(), exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_sw_high();
    for (int c = 0; c < 25; c++)
      sb.push_back(mk(2'b11, (c >= 13) ? 4'b0001 : 4'b0000, 2'b00, 2'b00,
                      (c == 13) ? 4'b0001 : 4'b0000));
    for (int c = 0; c < 25; c++) begin
      sw_in       = 4'b0001;
      reset_reset = (c < 3);
      exp_v = sb.pop_front();
      checks++;
      if (observe() !== exp_v) begin
        failures++;
        $display("FAIL reset_sw_high c=%0d got=%b want=%b", c, observe(), exp_v);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_press_hold();
    test_bounce();
    test_switch();
    test_simultaneous();
    test_reset_mid_hold();
    test_reset_sw_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
